// File: rtl/mx_pkg.sv
// Shared BF16/MX types and constants used by the block gatherer and its converter.
package mx_pkg;

   typedef struct packed {
      logic       sgn;
      logic [7:0] exp;
      logic [6:0] man;
   } bf16_t;

   localparam bf16_t BF16_ZERO = '0;
   localparam int    MX_K      = 32;

   typedef enum logic {
      S_FILL,
      S_FULL
   } gather_state_t;

endpackage

// File: rtl/bf16_gather_buf.sv
// One k-slot BF16 block buffer: lane-granular beat writes, reads masked to the first n_elem slots.
module bf16_gather_buf
   import mx_pkg::*;
#(
   parameter int k     = MX_K,
   parameter int lanes = 4,
   parameter int CW    = 3,
   parameter int NW    = 6
)(
   input  logic                    i_clk,
   input  logic                    i_we,
   input  logic [CW-1:0]           i_beat,
   input  logic [lanes-1:0][15:0]  i_data,
   input  logic [NW-1:0]           i_n_elem,
   output logic [k-1:0][15:0]      o_vec
);

   // Contents are never cleared; slots past n_elem read as zero so a short block pads itself.
   for (genvar gi = 0; gi < k; gi++) begin : g_slot
      bf16_t slot_reg;

      always_ff @(posedge i_clk) begin
         if (i_we && (i_beat == CW'(gi / lanes))) begin
            slot_reg <= bf16_t'(i_data[gi % lanes]);
         end
      end

      assign o_vec[gi] = (NW'(gi) < i_n_elem) ? slot_reg : BF16_ZERO;
   end

endmodule

// File: rtl/bf16_block_gather.sv
// Gathers lanes-wide BF16 beats into k-element zero-padded blocks for the MX converter.
// Define BF16_GATHER_DBL_BUF_EN for ping-pong buffering (full-rate input, no o_rdy gaps).
module bf16_block_gather
   import mx_pkg::*;
#(
   parameter int k     = MX_K,
   parameter int lanes = 4
)(
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_vld,
   output logic                        o_rdy,
   input  logic [lanes-1:0][15:0]      i_bf16,
   input  logic                        i_last,
   output logic                        o_vld,
   input  logic                        i_rdy,
   output logic [k-1:0][15:0]          o_bf16_vec,
   output logic [$clog2(k+1)-1:0]      o_n_elem,
   output logic                        o_last
);

   localparam int beats = k / lanes;
   localparam int CW    = (beats > 1) ? $clog2(beats) : 1;
   localparam int NW    = $clog2(k + 1);
`ifdef BF16_GATHER_DBL_BUF_EN
   localparam int NBUF  = 2;
`else
   localparam int NBUF  = 1;
`endif

   logic [CW-1:0]       cnt_reg;
   logic                rdy_reg;
   logic                accept;
   logic                complete;
   logic [NW-1:0]       blk_n;
   logic                blk_last;
   logic [NBUF-1:0]     we;
   logic [NW-1:0]       n_elem_reg [NBUF];
   logic                last_reg   [NBUF];
   logic [k-1:0][15:0]  vec        [NBUF];

   assign accept   = i_vld && rdy_reg;
   assign complete = accept && ((cnt_reg == CW'(beats - 1)) || i_last);
   assign blk_n    = NW'((int'(cnt_reg) + 1) * lanes);
   assign blk_last = i_last && (cnt_reg != CW'(beats - 1));
   assign o_rdy    = rdy_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_reg <= '0;
      end else if (complete) begin
         cnt_reg <= '0;
      end else if (accept) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
      bf16_gather_buf #(
         .k     (k),
         .lanes (lanes),
         .CW    (CW),
         .NW    (NW)
      ) u_buf (
         .i_clk    (i_clk),
         .i_we     (we[gi]),
         .i_beat   (cnt_reg),
         .i_data   (i_bf16),
         .i_n_elem (n_elem_reg[gi]),
         .o_vec    (vec[gi])
      );
   end

`ifdef BF16_GATHER_DBL_BUF_EN
   logic [1:0] full_reg, full_next;
   logic       wr_ptr_reg, rd_ptr_reg;

   always_comb begin
      full_next = full_reg;
      we        = '0;
      we[wr_ptr_reg] = accept;
      if (full_reg[rd_ptr_reg] && i_rdy) full_next[rd_ptr_reg] = 1'b0;
      if (complete)                      full_next[wr_ptr_reg] = 1'b1;
   end

   // wr_ptr only ever points at a full buffer when both are full, so o_rdy=0 guards it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         full_reg      <= '0;
         wr_ptr_reg    <= 1'b0;
         rd_ptr_reg    <= 1'b0;
         rdy_reg       <= 1'b0;
         n_elem_reg[0] <= '0;
         n_elem_reg[1] <= '0;
         last_reg[0]   <= 1'b0;
         last_reg[1]   <= 1'b0;
      end else begin
         full_reg <= full_next;
         rdy_reg  <= ~&full_next;
         if (full_reg[rd_ptr_reg] && i_rdy) rd_ptr_reg <= ~rd_ptr_reg;
         if (complete) begin
            wr_ptr_reg             <= ~wr_ptr_reg;
            n_elem_reg[wr_ptr_reg] <= blk_n;
            last_reg[wr_ptr_reg]   <= blk_last;
         end
      end
   end

   assign o_vld      = full_reg[rd_ptr_reg];
   assign o_bf16_vec = vec[rd_ptr_reg];
   assign o_n_elem   = n_elem_reg[rd_ptr_reg];
   assign o_last     = last_reg[rd_ptr_reg];
`else
   gather_state_t state_reg, state_next;
   logic          vld_reg;

   always_comb begin
      state_next = state_reg;
      we         = accept;
      unique case (state_reg)
         S_FILL:  if (complete) state_next = S_FULL;
         S_FULL:  if (i_rdy)    state_next = S_FILL;
         default: state_next = S_FILL;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= S_FILL;
         rdy_reg       <= 1'b0;
         vld_reg       <= 1'b0;
         n_elem_reg[0] <= '0;
         last_reg[0]   <= 1'b0;
      end else begin
         state_reg <= state_next;
         rdy_reg   <= (state_next == S_FILL);
         vld_reg   <= (state_next == S_FULL);
         if (complete) begin
            n_elem_reg[0] <= blk_n;
            last_reg[0]   <= blk_last;
         end
      end
   end

   assign o_vld      = vld_reg;
   assign o_bf16_vec = vec[0];
   assign o_n_elem   = n_elem_reg[0];
   assign o_last     = last_reg[0];
`endif

endmodule
